// File: rtl/mdu_iterative_pkg.sv
// Shared opcodes and FSM states for the iterative multiply/divide unit.
package mdu_iterative_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
  localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

endpackage

// File: rtl/mdu_sign_prep.sv
// Operand magnitude conversion and result-sign / special-case flags.
module mdu_sign_prep
  import mdu_iterative_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WORD-1:0]     a,
  input  logic [WORD-1:0]     b,
  output logic [WORD-1:0]     a_mag,
  output logic [WORD-1:0]     b_mag,
  output logic                negate,
  output logic                div_zero,
  output logic                overflow
);

  localparam logic [WORD-1:0] MOST_NEG = {1'b1, {(WORD-1){1'b0}}};

  logic sa;
  logic sb;
  logic is_div;
  logic is_rem;
  logic signed_div;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (op)
      MDU_MULH: begin
        sa = a[WORD-1];
        sb = b[WORD-1];
      end
      MDU_MULHSU: sa = a[WORD-1];
      MDU_DIV, MDU_REM: begin
        sa = a[WORD-1];
        sb = b[WORD-1];
      end
      default: ;
    endcase
  end

  // Most-negative input negates to itself: read as unsigned 2^(WORD-1).
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;

  assign is_div     = op[2];
  assign is_rem     = op[2] & op[1];
  assign signed_div = (op == MDU_DIV) || (op == MDU_REM);

  assign negate   = is_rem ? sa : (sa ^ sb);
  assign div_zero = is_div && (b == '0);
  assign overflow = signed_div && (a == MOST_NEG) && (b == '1);

endmodule

// File: rtl/mdu_iterative.sv
// Iterative M-extension unit: shift-add multiply, restoring divide.
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [WORD-1:0]     op_a_i,
  input  logic [WORD-1:0]     op_b_i,
  output logic [WORD-1:0]     result_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int W = WORD;

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0]    cnt;
  logic [2*W-1:0]      acc;
  logic [W-1:0]        mcand;
  logic [W-1:0]        a_q;
  logic [W-1:0]        res_q;
  logic [MDU_OP_W-1:0] op_q;
  logic                neg_q;
  logic                dz_q;
  logic                ovf_q;

  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic         neg;
  logic         dz;
  logic         ovf;

  mdu_sign_prep #(
    .WORD(W)
  ) u_prep (
    .op      (op_i),
    .a       (op_a_i),
    .b       (op_b_i),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .negate  (neg),
    .div_zero(dz),
    .overflow(ovf)
  );

  logic           accept;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     r_sh;
  logic [W:0]     diff;
  logic [2*W-1:0] div_next;

  assign accept = (state == S_IDLE) && start_i;

  // Multiply: acc = {partial, multiplier}, one multiplier bit per cycle.
  assign mul_sum  = {1'b0, acc[2*W-1:W]}
                  + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[W-1:1]};

  // Divide: acc = {remainder, dividend/quotient}.
  assign r_sh     = {acc[2*W-1:W], acc[W-1]};
  assign diff     = r_sh - {1'b0, mcand};
  assign div_next = diff[W]
                  ? {r_sh[W-1:0], acc[W-2:0], 1'b0}
                  : {diff[W-1:0], acc[W-2:0], 1'b1};

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start_i) state_n = S_BUSY;
      S_BUSY: if (cnt == CNT_W'(1)) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      a_q   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      cnt   <= CNT_W'(W);
      a_q   <= op_a_i;
      op_q  <= op_i;
      neg_q <= neg;
      dz_q  <= dz;
      ovf_q <= ovf;
      if (op_i[2]) begin
        acc   <= {{W{1'b0}}, a_mag};
        mcand <= b_mag;
      end else begin
        acc   <= {{W{1'b0}}, b_mag};
        mcand <= a_mag;
      end
    end else if (state == S_BUSY) begin
      cnt <= cnt - CNT_W'(1);
      acc <= op_q[2] ? div_next : mul_next;
    end
  end

  logic [2*W-1:0] full;
  logic [W-1:0]   div_raw;
  logic [W-1:0]   div_val;
  logic [W-1:0]   fin;

  assign full    = neg_q ? -acc : acc;
  assign div_raw = op_q[1] ? acc[2*W-1:W] : acc[W-1:0];
  assign div_val = neg_q ? -div_raw : div_raw;

  always_comb begin
    fin = full[2*W-1:W];
    if (dz_q)                fin = op_q[1] ? a_q : '1;
    else if (ovf_q)          fin = op_q[1] ? '0 : a_q;
    else if (op_q[2])        fin = div_val;
    else if (op_q == MDU_MUL) fin = full[W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               res_q <= '0;
    else if (state == S_DONE) res_q <= fin;
  end

  assign result_o = (state == S_DONE) ? fin : res_q;
  assign busy_o   = (state == S_BUSY);
  assign done_o   = (state == S_DONE);

endmodule
